// File: rtl/pc_pkg.sv
// Shared types for the program-counter sequencer: FSM states and next-PC select codes.
package pc_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } pc_state_e;

    typedef enum logic [2:0] {
        SEL_SEQ   = 3'd0,
        SEL_REDIR = 3'd1,
        SEL_MRET  = 3'd2,
        SEL_TRAP  = 3'd3,
        SEL_HOLD  = 3'd4
    } pc_sel_e;

endpackage

// File: rtl/pc_next_mux.sv
// Priority select of the next fetch address (trap > mret > redirect > sequential > hold)
// plus the alignment check on mret/redirect targets.
module pc_next_mux
    import pc_pkg::*;
#(
    parameter int unsigned     XLEN        = 32,
    parameter int unsigned     ILEN_BYTES  = 4,
    parameter logic [XLEN-1:0] TRAP_VECTOR = XLEN'(32'h0000_0100)
) (
    input  logic            trap,
    input  logic            mret,
    input  logic            redirect,
    input  logic            fetch_ready,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] next_pc,
    input  logic [XLEN-1:0] epc_in,
    input  logic [XLEN-1:0] redirect_pc,
    output pc_sel_e         sel,
    output logic [XLEN-1:0] target,
    output logic            misalign
);

    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(ILEN_BYTES - 1);

    always_comb begin
        sel    = SEL_HOLD;
        target = pc;
        if (trap) begin
            sel    = SEL_TRAP;
            target = TRAP_VECTOR;
        end else if (mret) begin
            sel    = SEL_MRET;
            target = epc_in;
        end else if (redirect) begin
            sel    = SEL_REDIR;
            target = redirect_pc;
        end else if (fetch_ready) begin
            sel    = SEL_SEQ;
            target = next_pc;
        end
    end

    // Target is passed through raw; the caller substitutes TRAP_VECTOR and keeps the raw value as bad_addr.
    assign misalign = ((sel == SEL_MRET) || (sel == SEL_REDIR)) && ((target & ALIGN_MASK) != '0);

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC register with BOOT/RUN/HALT control, trap/return/redirect handling,
// misalignment trapping and a completed-handshake counter.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
    parameter int unsigned     ILEN_BYTES   = 4,
    parameter int unsigned     CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             halt_req,
    input  logic             resume,
    input  logic             redirect,
    input  logic [XLEN-1:0]  redirect_pc,
    input  logic             trap,
    input  logic             mret,
    input  logic [XLEN-1:0]  epc_in,
    input  logic             fetch_ready,
    output logic [XLEN-1:0]  pc,
    output logic [XLEN-1:0]  next_pc,
    output logic             pc_valid,
    output logic             misalign,
    output logic [XLEN-1:0]  bad_addr,
    output logic             halted,
    output logic [CNT_W-1:0] fetch_cnt
);

    pc_state_e        state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic             misalign_q, misalign_d;
    logic [XLEN-1:0]  bad_addr_q, bad_addr_d;
    logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;

    pc_sel_e          mux_sel;
    logic [XLEN-1:0]  mux_target;
    logic             mux_misalign;

    assign next_pc = pc_q + XLEN'(ILEN_BYTES);

    pc_next_mux #(
        .XLEN        (XLEN),
        .ILEN_BYTES  (ILEN_BYTES),
        .TRAP_VECTOR (TRAP_VECTOR)
    ) u_next_mux (
        .trap        (trap),
        .mret        (mret),
        .redirect    (redirect),
        .fetch_ready (fetch_ready),
        .pc          (pc_q),
        .next_pc     (next_pc),
        .epc_in      (epc_in),
        .redirect_pc (redirect_pc),
        .sel         (mux_sel),
        .target      (mux_target),
        .misalign    (mux_misalign)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        misalign_d  = 1'b0;
        bad_addr_d  = bad_addr_q;
        fetch_cnt_d = fetch_cnt_q;
        unique case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN: begin
                pc_d = mux_misalign ? TRAP_VECTOR : mux_target;
                if (mux_misalign) begin
                    misalign_d = 1'b1;
                    bad_addr_d = mux_target;
                end
                // SEL_SEQ is exactly "handshake completed with no override this cycle".
                if (mux_sel == SEL_SEQ) begin
                    fetch_cnt_d = fetch_cnt_q + CNT_W'(1);
                end
                if (halt_req) begin
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                if (trap) begin
                    pc_d    = TRAP_VECTOR;
                    state_d = ST_RUN;
                end else if (resume) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_BOOT;
            pc_q        <= RESET_VECTOR;
            misalign_q  <= 1'b0;
            bad_addr_q  <= '0;
            fetch_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            misalign_q  <= misalign_d;
            bad_addr_q  <= bad_addr_d;
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

    assign pc        = pc_q;
    assign pc_valid  = (state_q == ST_RUN);
    assign halted    = (state_q == ST_HALT);
    assign misalign  = misalign_q;
    assign bad_addr  = bad_addr_q;
    assign fetch_cnt = fetch_cnt_q;

endmodule
